// File: rtl/pipelined_cla_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_cla_addsub : two-level carry-lookahead adder/subtractor with a
// 1..3 stage valid/ready pipeline.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipelined_cla_addsub #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  // Flat sum-of-products carries: c[k] = G[k-1] | P[k-1]G[k-2] | ... | P[k-1..0]c0
  function automatic logic [GROUP:0] bit_carries(input logic [GROUP-1:0] p,
                                                 input logic [GROUP-1:0] g,
                                                 input logic c0);
    logic [GROUP:0] c;
    logic           t;
    c = '0;
    for (int k = 0; k <= GROUP; k++) begin
      t = c0;
      for (int j = 0; j < k; j++) t = t & p[j];
      c[k] = t;
      for (int j = 0; j < k; j++) begin
        t = g[j];
        for (int m = j + 1; m < k; m++) t = t & p[m];
        c[k] = c[k] | t;
      end
    end
    return c;
  endfunction

  function automatic logic [NG:0] group_carries(input logic [NG-1:0] gp,
                                                input logic [NG-1:0] gg,
                                                input logic c0);
    logic [NG:0] c;
    logic        t;
    c = '0;
    for (int k = 0; k <= NG; k++) begin
      t = c0;
      for (int j = 0; j < k; j++) t = t & gp[j];
      c[k] = t;
      for (int j = 0; j < k; j++) begin
        t = gg[j];
        for (int m = j + 1; m < k; m++) t = t & gp[m];
        c[k] = c[k] | t;
      end
    end
    return c;
  endfunction

  logic advance;
  assign in_ready = !(out_valid && !out_ready);
  assign advance  = in_ready;

  // Front end: bit and group propagate/generate from the raw operands
  logic [WIDTH-1:0] f_p, f_g;
  logic [NG-1:0]    f_gp, f_gg;
  logic             f_c0;
  logic [GROUP:0]   f_tmp;

  always_comb begin
    f_c0  = sub | cin;
    f_p   = a ^ (b ^ {WIDTH{sub}});
    f_g   = a & (b ^ {WIDTH{sub}});
    f_tmp = '0;
    for (int k = 0; k < NG; k++) begin
      f_gp[k] = &f_p[k*GROUP +: GROUP];
      f_tmp   = bit_carries(f_p[k*GROUP +: GROUP], f_g[k*GROUP +: GROUP], 1'b0);
      f_gg[k] = f_tmp[GROUP];
    end
  end

  // Middle: group carry-ins
  logic [NG-1:0] m_gp, m_gg;
  logic          m_c0;
  logic [NG:0]   m_cg;

  assign m_cg = group_carries(m_gp, m_gg, m_c0);

  // Back end: in-group carries, sum and flags
  logic [WIDTH-1:0] k_p, k_g, k_sum;
  logic [NG:0]      k_cg;
  logic             k_valid, k_cmsb;
  logic [GROUP:0]   k_tmp;

  always_comb begin
    k_sum  = '0;
    k_cmsb = 1'b0;
    k_tmp  = '0;
    for (int k = 0; k < NG; k++) begin
      k_tmp = bit_carries(k_p[k*GROUP +: GROUP], k_g[k*GROUP +: GROUP], k_cg[k]);
      k_sum[k*GROUP +: GROUP] = k_p[k*GROUP +: GROUP] ^ k_tmp[GROUP-1:0];
      if (k == NG - 1) k_cmsb = k_tmp[GROUP-1];
    end
  end

  generate
    if (STAGES == 1) begin : g_one
      assign m_gp    = f_gp;
      assign m_gg    = f_gg;
      assign m_c0    = f_c0;
      assign k_p     = f_p;
      assign k_g     = f_g;
      assign k_cg    = m_cg;
      assign k_valid = in_valid;
    end else begin : g_multi
      logic             s1_valid, s1_c0;
      logic [WIDTH-1:0] s1_p, s1_g;
      logic [NG-1:0]    s1_gp, s1_gg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid <= 1'b0;
          s1_c0    <= 1'b0;
          s1_p     <= '0;
          s1_g     <= '0;
          s1_gp    <= '0;
          s1_gg    <= '0;
        end else if (advance) begin
          s1_valid <= in_valid;
          if (in_valid) begin
            s1_c0 <= f_c0;
            s1_p  <= f_p;
            s1_g  <= f_g;
            s1_gp <= f_gp;
            s1_gg <= f_gg;
          end
        end
      end

      assign m_gp = s1_gp;
      assign m_gg = s1_gg;
      assign m_c0 = s1_c0;

      if (STAGES == 2) begin : g_two
        assign k_p     = s1_p;
        assign k_g     = s1_g;
        assign k_cg    = m_cg;
        assign k_valid = s1_valid;
      end else begin : g_three
        logic             s2_valid;
        logic [WIDTH-1:0] s2_p, s2_g;
        logic [NG:0]      s2_cg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_p     <= '0;
            s2_g     <= '0;
            s2_cg    <= '0;
          end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
              s2_p  <= s1_p;
              s2_g  <= s1_g;
              s2_cg <= m_cg;
            end
          end
        end

        assign k_p     = s2_p;
        assign k_g     = s2_g;
        assign k_cg    = s2_cg;
        assign k_valid = s2_valid;
      end
    end
  endgenerate

  // Data registers load only with a valid token so bubbles never disturb outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      out_valid <= k_valid;
      if (k_valid) begin
        sum      <= k_sum;
        cout     <= k_cg[NG];
        overflow <= k_cmsb ^ k_cg[NG];
        zero     <= (k_sum == '0);
      end
    end
  end

endmodule

`default_nettype wire
